audio_mixer: RTL and testbench
==============================

# audio_mixer

Multi-channel audio mixer with per-channel volume feeding a first-order delta-sigma PWM modulator. It is the parametrised successor to the single-channel PWM output stage. Sound generators present parallel unsigned samples and a sample-rate strobe; the block latches a frame, mixes it sequentially over one channel per clock, and drives a 1-bit density-modulated output to the board's RC filter.

## Interface
- `WIDTH`, 6: unsigned sample width per channel.
- `CHANNELS`, 4: channel count, ≥2.
- `VOL_WIDTH`, 4: per-channel volume width. Gain = vol / 2^VOL_WIDTH.
- Derived (localparam): `MIX_WIDTH = WIDTH + $clog2(CHANNELS)`.
- `clk`  in  1  single system clock; everything is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sample_strobe`  in  1  one-cycle pulse requesting capture of a new frame.
- `data`  in  CHANNELS*WIDTH  packed samples, channel 0 in the LSBs.
- `volume`  in  CHANNELS*VOL_WIDTH  packed volumes, channel 0 in the LSBs.
- `busy`  out  1  high while a frame is being mixed.
- `overrun`  out  1  sticky flag: strobe arrived while busy.
- `level`  out  MIX_WIDTH  current mixed value driving the modulator.
- `pwm`  out  1  delta-sigma output (accumulator carry).

## Operation
- States: IDLE and MIX. Reset → IDLE.
- In IDLE, `sample_strobe` latches `data` and `volume` into shadow registers, clears the mix accumulator, sets the channel counter to 0, and moves to MIX.
- In MIX, one channel per cycle: `sum += (sample[ch] * vol[ch]) >> VOL_WIDTH`, using a product of WIDTH+VOL_WIDTH bits truncated to WIDTH bits. On the last channel, the final sum loads `level` and the state returns to IDLE.
- No saturation is required. The maximum sum is below 2^MIX_WIDTH by construction. Volume 0 mutes the channel.
- A strobe while in MIX is ignored: the frame is not restarted and the shadow registers are unchanged. It sets `overrun`, which clears only on reset.
- Input changes after the capture cycle have no effect on the frame in progress.
- Modulator, every cycle: `acc <= {1'b0, acc[MIX_WIDTH-1:0]} + level + cin`. Here `acc` is MIX_WIDTH+1 bits, `pwm = acc[MIX_WIDTH]`, and `cin = 0` unless dither is enabled.
- The long-run pwm duty is (level + E[cin]) / 2^MIX_WIDTH.
- Reset values: state IDLE, `busy` 0, `overrun` 0, `level` 0, `acc` 0, `pwm` 0, shadow registers 0, counter 0.
- Reset has priority over a strobe in the same cycle. Reset mid-MIX aborts the frame with no partial `level` update.

## Timing
- Strobe sampled at edge 0. `busy` is high in cycles 1..CHANNELS. `level` is updated and `busy` is low from cycle CHANNELS+1.
- `pwm` first reflects the new `level` at cycle CHANNELS+2, because the accumulator is registered.
- The next strobe is accepted from cycle CHANNELS+1. The minimum strobe period is CHANNELS+1 cycles.
- A strobe in the final MIX cycle (cycle CHANNELS) counts as an overrun.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `AUDIO_DITHER_EN` defined:
  - A 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances every cycle.
  - Its LSB is `cin`, adding a ½-LSB mean offset and breaking idle tones.
  - Accumulator bound still holds: (2^MIX_WIDTH−1) + level + 1 < 2^(MIX_WIDTH+1).
- Not defined: no LFSR logic, `cin = 0`. Output is bit-identical to the plain first-order modulator.

## Structure
- Shared package `audio_pkg`: state enum (IDLE, MIX), LFSR seed and tap constants, and the `MIX_WIDTH` helper function.
- One sub-module, `audio_dsm`. It contains the modulator accumulator plus the optional LFSR, is parametrised by MIX_WIDTH, and has inputs `clk`, `reset`, `level` and output `pwm`.
- The top contains the capture registers, the channel counter/FSM and the multiply-accumulate.

## Test plan
All cases use the defaults, so MIX_WIDTH = 8.
- Reset: all outputs 0. With no strobe, `pwm` stays 0 for 512 cycles.
- Single channel: ch0 = 32, vol0 = 15, other volumes 0, strobe at cycle 0.
  - `busy` is high in cycles 1–4.
  - `level` = 30 at cycle 5.
  - `pwm` high count over the next 256 cycles = 30.
- Full scale: all samples 63, all volumes 15 → `level` = 4×59 = 236; `pwm` high count over 256 cycles = 236.
- Overrun and latching: strobe at cycle 0, change `data` at cycle 1, strobe again at cycle 2.
  - `overrun` = 1 from cycle 3.
  - `level` reflects the cycle-0 frame.
  - `overrun` stays 1 until reset.
- Reset mid-mix: strobe at cycle 0, reset at cycle 2.
  - Cycle 3: `busy` = 0, `level` = 0.
  - A subsequent strobe mixes correctly.
- Dither (`AUDIO_DITHER_EN` defined), `level` = 0: over 65535 cycles the `pwm` high count is 128 ±1. The same test without the macro gives 0.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio mixer and its delta-sigma stage.
package audio_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MIX  = 1'b1
  } state_e;

  // Galois LFSR for optional dither: x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int mix_width(input int width, input int channels);
    return width + $clog2(channels);
  endfunction

endpackage

// File: rtl/audio_dsm.sv
// First-order delta-sigma modulator; pwm is the accumulator carry.
// Define AUDIO_DITHER_EN to add an LFSR-driven carry-in (dither).
module audio_dsm
  import audio_pkg::*;
#(
  parameter int MIX_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [MIX_WIDTH-1:0] i_level,
  output logic                 o_pwm
);

  logic [MIX_WIDTH:0] r_acc;
  logic               w_cin;

`ifdef AUDIO_DITHER_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_lfsr <= LFSR_SEED;
    else         r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

  assign w_cin = r_lfsr[0];
`else
  assign w_cin = 1'b0;
`endif

  // Carry from the previous add is dropped; only the residue is kept.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_acc <= '0;
    else         r_acc <= {1'b0, r_acc[MIX_WIDTH-1:0]} + {1'b0, i_level}
                          + (MIX_WIDTH+1)'(w_cin);
  end

  assign o_pwm = r_acc[MIX_WIDTH];

endmodule

// File: rtl/audio_mixer.sv
// Multi-channel mixer: latches a frame, mixes one channel per clock, drives audio_dsm.
// Optional dither in audio_dsm via AUDIO_DITHER_EN.
module audio_mixer
  import audio_pkg::*;
#(
  parameter  int WIDTH     = 6,
  parameter  int CHANNELS  = 4,
  parameter  int VOL_WIDTH = 4,
  localparam int MIX_WIDTH = mix_width(WIDTH, CHANNELS)
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_sample_strobe,
  input  logic [CHANNELS*WIDTH-1:0]     i_data,
  input  logic [CHANNELS*VOL_WIDTH-1:0] i_volume,
  output logic                          o_busy,
  output logic                          o_overrun,
  output logic [MIX_WIDTH-1:0]          o_level,
  output logic                          o_pwm
);

  localparam int CNT_W  = $clog2(CHANNELS);
  localparam int PROD_W = WIDTH + VOL_WIDTH;

  state_e                        r_state, w_next;
  logic [CHANNELS*WIDTH-1:0]     r_data;
  logic [CHANNELS*VOL_WIDTH-1:0] r_vol;
  logic [CNT_W-1:0]              r_cnt;
  logic [MIX_WIDTH-1:0]          r_sum, r_level, w_sum_nxt;
  logic                          r_overrun;
  logic                          w_capture, w_last;
  logic [WIDTH-1:0]              w_sample, w_term;
  logic [VOL_WIDTH-1:0]          w_vol;
  logic [PROD_W-1:0]             w_prod;

  assign w_sample  = r_data[r_cnt*WIDTH +: WIDTH];
  assign w_vol     = r_vol[r_cnt*VOL_WIDTH +: VOL_WIDTH];
  assign w_prod    = PROD_W'(w_sample) * PROD_W'(w_vol);
  assign w_term    = w_prod[PROD_W-1:VOL_WIDTH];
  assign w_sum_nxt = r_sum + MIX_WIDTH'(w_term);
  assign w_last    = (r_cnt == CNT_W'(CHANNELS-1));

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      IDLE: if (i_sample_strobe) begin
        w_capture = 1'b1;
        w_next    = MIX;
      end
      MIX:     if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_data    <= '0;
      r_vol     <= '0;
      r_cnt     <= '0;
      r_sum     <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_data <= i_data;
        r_vol  <= i_volume;
        r_sum  <= '0;
        r_cnt  <= '0;
      end else if (r_state == MIX) begin
        r_sum <= w_sum_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last) r_level <= w_sum_nxt;
      end
      // A strobe during any MIX cycle, including the last, is dropped.
      if (r_state == MIX && i_sample_strobe) r_overrun <= 1'b1;
    end
  end

  assign o_busy    = (r_state == MIX);
  assign o_overrun = r_overrun;
  assign o_level   = r_level;

  audio_dsm #(.MIX_WIDTH(MIX_WIDTH)) u_dsm (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_level (r_level),
    .o_pwm   (o_pwm)
  );

endmodule

// File: tb/tb_audio_mixer.sv
// Directed bench for audio_mixer with a frame-level reference model and cycle compare.
module tb_audio_mixer;
  localparam int W = 6, CH = 4, VW = 4, MW = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              strobe = 1'b0;
  logic [CH*W-1:0]   data = '0;
  logic [CH*VW-1:0]  volume = '0;
  logic              busy, overrun, pwm;
  logic [MW-1:0]     level;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  audio_mixer #(.WIDTH(W), .CHANNELS(CH), .VOL_WIDTH(VW)) dut (
    .i_clk(clk), .i_reset(reset), .i_sample_strobe(strobe), .i_data(data),
    .i_volume(volume), .o_busy(busy), .o_overrun(overrun), .o_level(level), .o_pwm(pwm)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CH*W-1:0] pk_d(input int a, b, c, d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  function automatic logic [CH*VW-1:0] pk_v(input int a, b, c, d);
    return {VW'(d), VW'(c), VW'(b), VW'(a)};
  endfunction

  // Frame result straight from the gain rule: sum of floor(sample*vol/16).
  function automatic int mix_ref(input logic [CH*W-1:0] d, input logic [CH*VW-1:0] v);
    int s = 0;
    for (int i = 0; i < CH; i++) s += (int'(d[i*W +: W]) * int'(v[i*VW +: VW])) / 16;
    return s;
  endfunction

  // Reference model: frames take CH cycles; pwm carries track the running sum of levels.
  int     m_left = 0, m_level = 0, m_pend = 0;
  bit     m_ovr = 1'b0, m_pwm = 1'b0;
  longint m_cum = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0; m_level = 0; m_ovr = 1'b0; m_cum = 0; m_pwm = 1'b0;
    end else begin
      m_pwm = ((m_cum + m_level) / 256) != (m_cum / 256);
      m_cum = m_cum + m_level;
      if (m_left > 0) begin
        if (strobe) m_ovr = 1'b1;
        m_left--;
        if (m_left == 0) m_level = m_pend;
      end else if (strobe) begin
        m_pend = mix_ref(data, volume);
        m_left = CH;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", int'(busy), int'(m_left != 0));
      chk("level", int'(level), m_level);
      chk("overrun", int'(overrun), int'(m_ovr));
`ifndef AUDIO_DITHER_EN
      chk("pwm", int'(pwm), int'(m_pwm));
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1; strobe = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  // Strobe held through cycle 0; returns at start of cycle 1.
  task automatic frame(input logic [CH*W-1:0] d, input logic [CH*VW-1:0] v);
    data = d; volume = v; strobe = 1'b1;
    tick(1);
    strobe = 1'b0;
  endtask

  task automatic pwm_count(input int n, output int c);
    c = 0;
    repeat (n) begin @(negedge clk); c += int'(pwm); end
  endtask

  initial begin
    int c;
    @(posedge clk); #1;
    do_reset();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_pwm", int'(pwm), 0);
`ifndef AUDIO_DITHER_EN
    pwm_count(512, c);
    chk("idle_pwm_cnt", c, 0);
`endif

    // Single channel, literal timing.
    @(posedge clk); #1;
    frame(pk_d(32, 0, 0, 0), pk_v(15, 0, 0, 0));
    for (int i = 1; i <= CH; i++) begin
      @(negedge clk);
      chk("single_busy", int'(busy), 1);
    end
    @(negedge clk);
    chk("single_busy_done", int'(busy), 0);
    chk("single_level", int'(level), 30);
`ifndef AUDIO_DITHER_EN
    pwm_count(256, c);
    chk("single_pwm_cnt", c, 30);
`endif

    // Full scale.
    @(posedge clk); #1;
    frame(pk_d(63, 63, 63, 63), pk_v(15, 15, 15, 15));
    tick(CH);
    @(negedge clk);
    chk("full_level", int'(level), 236);
`ifndef AUDIO_DITHER_EN
    pwm_count(256, c);
    chk("full_pwm_cnt", c, 236);
`endif

    // Mixed gains, including a mute-ish small product.
    @(posedge clk); #1;
    frame(pk_d(5, 17, 33, 63), pk_v(1, 4, 9, 15));
    tick(CH);
    @(negedge clk);
    chk("mixed_level", int'(level), 81);

    // Overrun and input latching.
    @(posedge clk); #1;
    frame(pk_d(10, 20, 30, 40), pk_v(8, 8, 8, 8));
    data = pk_d(63, 63, 63, 63);
    tick(1);
    strobe = 1'b1;
    tick(1);
    strobe = 1'b0;
    @(negedge clk);
    chk("ovr_set", int'(overrun), 1);
    tick(2);
    @(negedge clk);
    chk("ovr_level", int'(level), 50);
    tick(20);
    @(negedge clk);
    chk("ovr_sticky", int'(overrun), 1);

    // Reset mid-mix.
    do_reset();
    @(posedge clk); #1;
    frame(pk_d(63, 63, 63, 63), pk_v(15, 15, 15, 15));
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_level", int'(level), 0);
    chk("midrst_ovr", int'(overrun), 0);
    @(posedge clk); #1;
    frame(pk_d(5, 17, 33, 63), pk_v(1, 4, 9, 15));
    tick(CH);
    @(negedge clk);
    chk("after_rst_level", int'(level), 81);

    // Back-to-back at minimum period; model checks every cycle.
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      frame(CH*W'($urandom), CH*VW'($urandom));
      tick(CH);
    end
    tick(3);
    chk("b2b_no_ovr", int'(overrun), 0);

    // Strobe landing on the final MIX cycle.
    frame(pk_d(1, 2, 3, 4), pk_v(15, 15, 15, 15));
    tick(CH - 1);
    strobe = 1'b1;
    tick(1);
    strobe = 1'b0;
    @(negedge clk);
    chk("last_cycle_ovr", int'(overrun), 1);
    tick(10);

`ifdef AUDIO_DITHER_EN
    chk_en = 1'b0;
    do_reset();
    pwm_count(65535, c);
    chk("dither_cnt_in_range", int'(c >= 127 && c <= 129), 1);
`endif

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
